// File: rtl/pipeline_control_unit_pkg.sv
// pipeline_control_unit_pkg: shared state encoding and widths for the pipeline control unit
package pipeline_control_unit_pkg;
  localparam int PIPE_CTRL_WAIT_W = 8;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping
module sat_counter
  import pipeline_control_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  // advance only while below the saturation value
  always_comb count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: stall/flush sequencer merging hazards, data-memory wait and MDU wait
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               is_data_stall,
  input  logic               is_control_hazard,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  input  logic               mdu_start,
  input  logic               mdu_done,
  output logic               pc_en,
  output logic               if_id_en,
  output logic               id_ex_en,
  output logic               ex_mem_en,
  output logic               mem_wb_en,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_flush,
  output logic               mem_timeout,
  output logic [1:0]         ctrl_state,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);
  localparam logic [PIPE_CTRL_WAIT_W-1:0] TIMEOUT_CMP = PIPE_CTRL_WAIT_W'(MEM_TIMEOUT);
  pipe_ctrl_state_t state_q, state_d;
  logic [PIPE_CTRL_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic done_seen_q, done_seen_d, mem_timeout_q, mem_timeout_d;
  logic mem_freeze, done_eff, mdu_wait, hazard, dstall;
  // priority resolution and per-stage enables/flushes; the MEM_WAIT release cycle behaves as RUN
  always_comb begin
    mem_freeze   = dmem_req && !dmem_ready;
    done_eff     = mdu_done || done_seen_q;
    mdu_wait     = !mem_freeze && ((state_q == MDU_WAIT) ? !done_eff : mdu_start);
    hazard       = !mem_freeze && !mdu_wait && is_control_hazard;
    dstall       = !mem_freeze && !mdu_wait && !is_control_hazard && is_data_stall;
    pc_en        = !reset_n || !(mem_freeze || mdu_wait || dstall);
    if_id_en     = !reset_n || !(mem_freeze || mdu_wait || dstall);
    id_ex_en     = !reset_n || !(mem_freeze || mdu_wait);
    ex_mem_en    = !reset_n || !mem_freeze;
    mem_wb_en    = !reset_n || !mem_freeze;
    if_id_flush  = reset_n && hazard;
    id_ex_flush  = reset_n && (hazard || dstall);
    ex_mem_flush = reset_n && (hazard || mdu_wait);
  end
  // next state, memory-wait counter, deferred MDU completion and sticky watchdog
  always_comb begin
    state_d       = RUN;
    wait_cnt_d    = '0;
    done_seen_d   = 1'b0;
    mem_timeout_d = mem_timeout_q || (state_q == MEM_WAIT && wait_cnt_q == TIMEOUT_CMP);
    case (state_q)
      RUN, MEM_WAIT: begin
        state_d    = mem_freeze ? MEM_WAIT : mdu_start ? MDU_WAIT : RUN;
        wait_cnt_d = !mem_freeze ? '0
                   : (state_q == RUN) ? PIPE_CTRL_WAIT_W'(1)
                   : (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
      MDU_WAIT: begin
        state_d     = (done_eff && !mem_freeze) ? RUN : MDU_WAIT;
        done_seen_d = done_eff && mem_freeze;
      end
      default: state_d = RUN;
    endcase
  end
  // control state registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      done_seen_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      done_seen_q   <= done_seen_d;
      mem_timeout_q <= mem_timeout_d;
    end
  assign ctrl_state  = state_q;
  assign mem_timeout = mem_timeout_q;
  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(mem_freeze || mdu_wait || dstall), .count(stall_count)
  );
  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk(clk), .reset_n(reset_n), .inc(hazard), .count(flush_count)
  );
endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the hazard detection unit outputs (is_data_stall, is_control_hazard) with a data-memory ready handshake and a multi-cycle multiply/divide unit. From these it generates per-stage pipeline-register enables and flushes. It also keeps a memory-wait watchdog and saturating stall/flush performance counters for debug.

Parameters:
MEM_TIMEOUT, 255, wait cycles in MEM_WAIT before mem_timeout sets; 8-bit compare.
COUNT_W, 32, width of the stall_count and flush_count performance counters.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
is_data_stall  input  1  load-use stall request from the hazard detection unit
is_control_hazard  input  1  branch/jump redirect resolved in MEM
dmem_req  input  1  MEM stage holds a valid load/store
dmem_ready  input  1  data memory completes the access this cycle
mdu_start  input  1  EX holds an unfinished mul/div (level)
mdu_done  input  1  MDU result valid this cycle (pulse)
pc_en  output  1  PC register write enable
if_id_en  output  1  IF/ID write enable
id_ex_en  output  1  ID/EX write enable
ex_mem_en  output  1  EX/MEM write enable
mem_wb_en  output  1  MEM/WB write enable
if_id_flush  output  1  load NOP into IF/ID
id_ex_flush  output  1  load bubble into ID/EX
ex_mem_flush  output  1  load bubble into EX/MEM
mem_timeout  output  1  sticky memory watchdog error
ctrl_state  output  2  current FSM state (pipe_ctrl_state_t)
stall_count  output  COUNT_W  saturating count of cycles with pc_en=0
flush_count  output  COUNT_W  saturating count of control-hazard flush cycles

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low.
- All enables and flushes are combinational from the registered state and the current inputs, so they take effect in the same cycle.
- State, wait_cnt, mem_timeout and both counters are registers.
- Reset values:
  - state = RUN, wait_cnt = 0, mem_timeout = 0, stall_count = 0, flush_count = 0.
  - While reset_n is low, all enables = 1 and all flushes = 0.
  - Asserting reset mid-wait abandons the wait immediately.
- Definition: mem_freeze = dmem_req && !dmem_ready.
- Priority, highest first: mem_freeze > MDU wait > control hazard > data stall > normal.
- mem_freeze, in any state:
  - All five enables = 0 and all flushes = 0.
  - Any control hazard is deferred. Its input stays asserted because MEM is frozen, so the flush applies on the release cycle.
- MDU wait: state == MDU_WAIT && !mdu_done, or state == RUN && mdu_start (the entry cycle).
  - pc_en, if_id_en and id_ex_en = 0.
  - ex_mem_en = 1 with ex_mem_flush = 1, so a bubble drains downstream.
  - mem_wb_en = 1.
- Control hazard (no freeze, no MDU wait):
  - All enables = 1.
  - if_id_flush, id_ex_flush and ex_mem_flush = 1.
  - is_data_stall is ignored.
- Data stall:
  - pc_en = 0 and if_id_en = 0.
  - id_ex_en = 1 with id_ex_flush = 1.
  - ex_mem_en and mem_wb_en = 1.
- Normal: all enables = 1 and all flushes = 0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_freeze; wait_cnt <= 1.
  - RUN -> MDU_WAIT when mdu_start && !mem_freeze.
  - MEM_WAIT stays while mem_freeze; wait_cnt increments and saturates at 255.
  - MEM_WAIT -> RUN on the first cycle with !mem_freeze. That cycle uses RUN rules; a pending MDU op re-enters MDU_WAIT on the next edge.
  - MDU_WAIT stays until mdu_done && !mem_freeze. The done cycle uses RUN rules (control hazard, data stall, normal), then the FSM returns to RUN.
  - mdu_done with mem_freeze in the same cycle is not lost: the FSM stays in MDU_WAIT with an internal done_seen flag set, and releases on the first non-frozen cycle.
  - The encoding value 3 is unreachable and recovers to RUN.
- Watchdog: mem_timeout sets when wait_cnt == MEM_TIMEOUT while in MEM_WAIT. It is sticky until reset and does not unfreeze the pipeline.
- Counters:
  - stall_count increments on every cycle with pc_en == 0.
  - flush_count increments on every cycle with if_id_flush == 1.
  - Both saturate at all-ones and never wrap.

Decomposition:
- The common package gains:
  - pipe_ctrl_state_t enum {RUN = 0, MEM_WAIT = 1, MDU_WAIT = 2} as logic [1:0].
  - The localparam PIPE_CTRL_WAIT_W = 8.
- One sub-module, sat_counter (parameter W; inputs inc, clk, reset_n; output count).
  - Instantiated twice, for stall_count and flush_count.

Test Plan:
1. Reset release, no requests -> all enables 1, flushes 0, ctrl_state = RUN, both counters 0.
2. is_data_stall for 1 cycle:
   - that cycle: pc_en = 0, if_id_en = 0, id_ex_flush = 1;
   - next cycle: normal;
   - stall_count = 1.
3. dmem_req = 1 with dmem_ready low for 3 cycles, then high:
   - all enables 0 for 3 cycles;
   - ctrl_state = MEM_WAIT from the 2nd cycle;
   - release cycle all enables 1;
   - stall_count = 3.
4. is_control_hazard during a 2-cycle mem_freeze:
   - no flush while frozen;
   - the release cycle shows if_id, id_ex and ex_mem flushes = 1;
   - flush_count = 1.
5. mdu_start high and mdu_done pulsing 4 cycles later:
   - pc_en = 0 and ex_mem_flush = 1 for 4 cycles;
   - the done cycle advances all stages;
   - ctrl_state returns to RUN.
6. MEM_TIMEOUT = 4 with dmem_ready held low for 10 cycles:
   - mem_timeout rises when wait_cnt reaches 4 and stays high after dmem_ready;
   - reset_n low clears it asynchronously.
